// File: rtl/mux4_rr_scheduler_if.sv
// Handshake bundle for the 4-requester round-robin 1-bit mux scheduler.
// The master side drives requests, data and back-pressure; the slave side is the scheduler.
interface mux4_rr_scheduler_if;
  logic [3:0] req;
  logic [3:0] din;
  logic       out_ready;
  logic [1:0] sel;
  logic [3:0] gnt;
  logic       y;
  logic       y_valid;
  logic       busy;

  modport master (
    output req, din, out_ready,
    input  sel, gnt, y, y_valid, busy
  );

  modport slave (
    input  req, din, out_ready,
    output sel, gnt, y, y_valid, busy
  );
endinterface

// File: rtl/mux4_rr_scheduler.sv
// Round-robin 4:1 scheduler: grants one requester at a time, samples its data bit into a
// one-entry output register with ready/valid back-pressure, and releases after HOLD_MAX samples.
module mux4_rr_scheduler #(
  parameter int HOLD_MAX = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mux4_rr_scheduler_if.slave   bus
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t     state;
  logic [1:0] last;
  logic [3:0] hold_cnt;
  logic [1:0] pick;
  logic       sample;
  logic       xfer;
  logic       last_sample;

  // First set request searching last+1, last+2, last+3, last (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] idx;
    rr_pick = l;
    for (int k = 4; k >= 1; k--) begin
      idx = l + k[1:0];
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign pick        = rr_pick(bus.req, last);
  assign xfer        = bus.y_valid & bus.out_ready;
  assign sample      = (state == GRANT) & bus.req[bus.sel] & (~bus.y_valid | bus.out_ready);
  assign last_sample = (hold_cnt == 4'(HOLD_MAX - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus.gnt   <= 4'b0000;
      bus.sel   <= 2'd0;
      bus.y     <= 1'b0;
      bus.y_valid <= 1'b0;
      bus.busy  <= 1'b0;
      hold_cnt  <= 4'd0;
      last      <= 2'd3;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) bus.y_valid <= 1'b0;
          if (|bus.req) begin
            state    <= GRANT;
            bus.busy <= 1'b1;
            bus.sel  <= pick;
            bus.gnt  <= 4'b0001 << pick;
          end
        end
        GRANT: begin
          if (sample) begin
            bus.y       <= bus.din[bus.sel];
            bus.y_valid <= 1'b1;
            if (last_sample) begin
              state    <= IDLE;
              bus.busy <= 1'b0;
              bus.gnt  <= 4'b0000;
              last     <= bus.sel;
              hold_cnt <= 4'd0;
            end else begin
              hold_cnt <= hold_cnt + 4'd1;
            end
          end else if (!bus.req[bus.sel]) begin
            // Requester withdrew: release without sampling, but still honour a pending transfer.
            if (xfer) bus.y_valid <= 1'b0;
            state    <= IDLE;
            bus.busy <= 1'b0;
            bus.gnt  <= 4'b0000;
            last     <= bus.sel;
            hold_cnt <= 4'd0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mux4_rr_scheduler.sv
// Bench for mux4_rr_scheduler: vector table, directed multi-cycle sequences, and randomized
// traffic compared each cycle against a behavioural reference model.
module tb_mux4_rr_scheduler;

  localparam int HOLD_MAX = 4;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mux4_rr_scheduler_if bus ();

  mux4_rr_scheduler #(.HOLD_MAX(HOLD_MAX)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: owner = -1 when nobody holds the grant.
  int         m_owner;
  int         m_last;
  int         m_cnt;
  logic [1:0] m_sel;
  logic       m_y;
  logic       m_yv;

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [3:0] d, input logic o);
    logic transfer;
    int   idx;
    if (r) begin
      m_owner = -1; m_last = 3; m_cnt = 0; m_sel = 2'd0; m_y = 1'b0; m_yv = 1'b0;
    end else begin
      transfer = m_yv && o;
      if (m_owner < 0) begin
        if (transfer) m_yv = 1'b0;
        for (int k = 1; k <= 4; k++) begin
          idx = (m_last + k) % 4;
          if (m_owner < 0 && rq[idx]) begin
            m_owner = idx;
            m_sel   = 2'(idx);
          end
        end
      end else if (rq[m_owner]) begin
        if (!m_yv || o) begin
          m_y  = d[m_owner];
          m_yv = 1'b1;
          m_cnt++;
          if (m_cnt == HOLD_MAX) begin
            m_last = m_owner; m_owner = -1; m_cnt = 0;
          end
        end
      end else begin
        if (transfer) m_yv = 1'b0;
        m_last = m_owner; m_owner = -1; m_cnt = 0;
      end
    end
  endtask

  function automatic logic [8:0] model_vec();
    logic [3:0] g;
    g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    return {(m_owner >= 0), g, m_sel, m_y, m_yv};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs across one rising edge, then compare 1ns later against the model.
  task automatic step(input logic r, input logic [3:0] rq, input logic [3:0] d, input logic o);
    logic onehot_ok;
    rst = r; bus.req = rq; bus.din = d; bus.out_ready = o;
    @(posedge clk);
    model_step(r, rq, d, o);
    #1;
    chk("model {busy,gnt,sel,y,y_valid}",
        32'({bus.busy, bus.gnt, bus.sel, bus.y, bus.y_valid}), 32'(model_vec()));
    onehot_ok = ($countones(bus.gnt) == 0) ||
                (($countones(bus.gnt) == 1) && bus.gnt[bus.sel]);
    chk("gnt_onehot_matches_sel", 32'(onehot_ok), 32'd1);
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] din;
    logic       ordy;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       y;
    logic       yv;
    logic       busy;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int n;
    checks = 0; failures = 0;
    rst = 1'b1; bus.req = 4'd0; bus.din = 4'd0; bus.out_ready = 1'b0;

    // Single requester 0: grant, four samples, release, one idle cycle, regrant.
    tbl[0] = '{1'b1, 4'b0000, 4'b0000, 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0};
    tbl[6] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 4'b0001, 4'b0001, 1'b1, 4'b0001, 2'd0, 1'b1, 1'b1, 1'b1};

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].req, tbl[i].din, tbl[i].ordy);
      chk($sformatf("table[%0d]", i),
          32'({bus.busy, bus.gnt, bus.sel, bus.y, bus.y_valid}),
          32'({tbl[i].busy, tbl[i].gnt, tbl[i].sel, tbl[i].y, tbl[i].yv}));
    end

    // All requesting: order 0,1,2,3,0, four grant cycles then one idle cycle each.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    for (int s = 1; s <= 24; s++) begin
      logic [3:0] eg;
      step(1'b0, 4'b1111, 4'($urandom), 1'b1);
      eg = (((s - 1) % 5) < 4) ? (4'b0001 << (((s - 1) / 5) % 4)) : 4'b0000;
      chk($sformatf("rr_order_step%0d", s), 32'(bus.gnt), 32'(eg));
    end

    // Requester 2 stalled by out_ready low after its first sample.
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b0100, 4'b0100, 1'b0);
    chk("stall_grant2", 32'(bus.gnt), 32'(4'b0100));
    step(1'b0, 4'b0100, 4'b0100, 1'b0);
    for (int s = 0; s < 3; s++) begin
      step(1'b0, 4'b0100, 4'b0000, 1'b0);
      chk("stall_hold {gnt,y,y_valid}", 32'({bus.gnt, bus.y, bus.y_valid}), 32'({4'b0100, 2'b11}));
    end
    n = 0;
    while (bus.busy && n < 10) begin
      step(1'b0, 4'b0100, 4'b0100, 1'b1);
      n++;
    end
    chk("stall_resume_samples_to_release", 32'(n), 32'd3);

    // Requester 1 drops after two samples; pending 1001 picks requester 3 next.
    step(1'b1, 4'b0000, 4'b0000, 1'b1);
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    chk("drop_grant1", 32'(bus.gnt), 32'(4'b0010));
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    step(1'b0, 4'b0010, 4'b0010, 1'b1);
    step(1'b0, 4'b1001, 4'b0000, 1'b1);
    chk("drop_release {busy,gnt,sel}", 32'({bus.busy, bus.gnt, bus.sel}), 32'({1'b0, 4'b0000, 2'd1}));
    step(1'b0, 4'b1001, 4'b0000, 1'b1);
    chk("drop_next_grant3 {gnt,sel}", 32'({bus.gnt, bus.sel}), 32'({4'b1000, 2'd3}));

    // Reset mid-grant of requester 3 with a pending sample.
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    step(1'b0, 4'b1000, 4'b1000, 1'b0);
    step(1'b0, 4'b1000, 4'b1000, 1'b0);
    chk("midrst_pending {gnt,y,y_valid}", 32'({bus.gnt, bus.y, bus.y_valid}), 32'({4'b1000, 2'b11}));
    step(1'b1, 4'b1010, 4'b1111, 1'b0);
    chk("midrst_cleared {busy,gnt,sel,y,y_valid}",
        32'({bus.busy, bus.gnt, bus.sel, bus.y, bus.y_valid}), 32'd0);
    step(1'b0, 4'b1010, 4'b0000, 1'b0);
    chk("midrst_first_grant1", 32'(bus.gnt), 32'(4'b0010));

    // Randomized traffic against the model.
    step(1'b1, 4'b0000, 4'b0000, 1'b0);
    for (int c = 0; c < 3000; c++) begin
      logic [3:0] rq;
      rq = ($urandom_range(0, 7) == 0) ? 4'b0000 : 4'($urandom);
      step(($urandom_range(0, 99) == 0), rq, 4'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
